// File: rtl/logic_unit_pkg.sv
// Shared types for the serial logic unit: operation codes, FSM state encoding and datapath width.
package logic_unit_pkg;

   localparam int XLEN = 64;

   typedef enum logic [1:0] {
      OP_AND  = 2'b00,
      OP_OR   = 2'b01,
      OP_XOR  = 2'b10,
      OP_ANDN = 2'b11
   } op_t;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_BUSY = 2'd1;
   localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/logic_slice.sv
// Combinational bitwise operator applied to one SLICE_W-bit slice of the operands.
module logic_slice
   import logic_unit_pkg::*;
#(
   parameter int SLICE_W = 16
) (
   input  logic [SLICE_W-1:0] i_a,
   input  logic [SLICE_W-1:0] i_b,
   input  op_t                i_op,
   output logic [SLICE_W-1:0] o_res
);

   // NOTE: o_res gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      o_res = '0;
      case (i_op)
         OP_AND:  o_res = i_a & i_b;
         OP_OR:   o_res = i_a | i_b;
         OP_XOR:  o_res = i_a ^ i_b;
         OP_ANDN: o_res = i_a & ~i_b;
         default: o_res = '0;
      endcase
   end

endmodule

// File: rtl/serial_logic_unit.sv
// 64-bit bitwise logic unit that computes SLICE_W bits per cycle behind a valid/ready handshake.
// Optional zero-result flag enabled by defining SERIAL_LOGIC_ZERO_FLAG_EN.
module serial_logic_unit
   import logic_unit_pkg::*;
#(
   parameter int SLICE_W = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] A,
   input  logic [XLEN-1:0] B,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic [XLEN-1:0] result
`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
   ,
   output logic            zero
`endif
);

   localparam int NSLICE = XLEN / SLICE_W;
   localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NSLICE - 1);

   state_t                          r_state;
   logic [CNT_W-1:0]                r_cnt;
   logic [NSLICE-1:0][SLICE_W-1:0]  r_a;
   logic [NSLICE-1:0][SLICE_W-1:0]  r_b;
   logic [NSLICE-1:0][SLICE_W-1:0]  r_result;
   op_t                             r_op;
   logic [SLICE_W-1:0]              w_slice_res;

   assign req_ready  = (r_state == ST_IDLE);
   assign resp_valid = (r_state == ST_DONE);
   assign result     = r_result;

   // The packed slice view turns the counter into a plain index for the operand mux.
   logic_slice #(.SLICE_W(SLICE_W)) u_slice (
      .i_a   (r_a[r_cnt]),
      .i_b   (r_b[r_cnt]),
      .i_op  (r_op),
      .o_res (w_slice_res)
   );

   // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_op     <= OP_AND;
         r_result <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (req_valid) begin
                  r_a     <= A;
                  r_b     <= B;
                  r_op    <= op_t'(op);
                  r_cnt   <= '0;
                  r_state <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               r_result[r_cnt] <= w_slice_res;
               // Counter parks on the last slice rather than wrapping.
               if (r_cnt == LAST_SLICE) r_state <= ST_DONE;
               else                     r_cnt   <= r_cnt + CNT_W'(1);
            end
            ST_DONE: begin
               if (resp_ready) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
   logic r_zero;

   // Folded one slice at a time so no 64-bit reduction sits in a single cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_zero <= 1'b0;
      end else if (r_state == ST_IDLE && req_valid) begin
         r_zero <= 1'b1;
      end else if (r_state == ST_BUSY) begin
         r_zero <= r_zero & ~(|w_slice_res);
      end
   end

   assign zero = r_zero & resp_valid;
`endif

endmodule

// File: tb/tb_serial_logic_unit.sv
// Directed bench for serial_logic_unit: vector table plus backpressure, operand-change,
// mid-operation reset and back-to-back sequences. Zero flag checked when SERIAL_LOGIC_ZERO_FLAG_EN is set.
module tb_serial_logic_unit;

   localparam int SLICE_W = 16;
   localparam int LAT     = 64 / SLICE_W;
   localparam int BOUND   = 20;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  op;
   logic [63:0] a;
   logic [63:0] b;
   logic        resp_valid;
   logic        resp_ready;
   logic [63:0] result;
`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
   logic        zero;
`endif

   int n_checks = 0;
   int n_errors = 0;

   serial_logic_unit #(.SLICE_W(SLICE_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .op         (op),
      .A          (a),
      .B          (b),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .result     (result)
`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
      ,
      .zero       (zero)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]  op;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] exp;
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready(input string name);
      int n;
      n = 0;
      while (!req_ready && n < BOUND) begin
         tick();
         n++;
      end
      check({name, " req_ready timeout"}, {63'd0, req_ready}, 64'd1);
   endtask

   task automatic wait_resp(input string name, output int lat);
      lat = 0;
      while (lat < BOUND) begin
         tick();
         lat++;
         if (resp_valid) break;
      end
      check({name, " resp_valid seen"}, {63'd0, resp_valid}, 64'd1);
   endtask

   task automatic run_op(input string name, input logic [1:0] o, input logic [63:0] va,
                         input logic [63:0] vb, input logic [63:0] exp);
      int lat;
      wait_ready(name);
      req_valid  = 1'b1;
      op         = o;
      a          = va;
      b          = vb;
      resp_ready = 1'b1;
      tick();
      req_valid = 1'b0;
      check({name, " req_ready after accept"}, {63'd0, req_ready}, 64'd0);
      wait_resp(name, lat);
      check({name, " latency"}, 64'(lat), 64'(LAT));
      check({name, " result"}, result, exp);
`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
      check({name, " zero"}, {63'd0, zero}, {63'd0, (exp == 64'd0)});
`endif
      tick();
      check({name, " resp_valid after handshake"}, {63'd0, resp_valid}, 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int lat;

      vecs[0] = '{op: 2'b00, a: 64'hFFFF0000FFFF0000, b: 64'h0F0F0F0F0F0F0F0F, exp: 64'h0F0F00000F0F0000};
      vecs[1] = '{op: 2'b11, a: 64'hFFFFFFFFFFFFFFFF, b: 64'h00000000FFFFFFFF, exp: 64'hFFFFFFFF00000000};
      vecs[2] = '{op: 2'b01, a: 64'h00FF00FF00FF00FF, b: 64'hF000000000000000, exp: 64'hF0FF00FF00FF00FF};
      vecs[3] = '{op: 2'b10, a: 64'hAAAAAAAAAAAAAAAA, b: 64'hFFFF0000FFFF0000, exp: 64'h5555AAAA5555AAAA};
      vecs[4] = '{op: 2'b11, a: 64'h123456789ABCDEF0, b: 64'hFFFFFFFF00000000, exp: 64'h000000009ABCDEF0};
      vecs[5] = '{op: 2'b00, a: 64'h0000000000000000, b: 64'hFFFFFFFFFFFFFFFF, exp: 64'h0000000000000000};

      reset      = 1'b1;
      req_valid  = 1'b0;
      resp_ready = 1'b0;
      op         = 2'b00;
      a          = '0;
      b          = '0;
      tick();
      tick();
      check("reset req_ready", {63'd0, req_ready}, 64'd1);
      check("reset resp_valid", {63'd0, resp_valid}, 64'd0);
      check("reset result", result, 64'd0);
`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
      check("reset zero", {63'd0, zero}, 64'd0);
`endif
      reset = 1'b0;
      tick();

      for (int i = 0; i < 6; i++) begin
         run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
      end

      // Backpressure: XOR of equal operands, consumer stalls for 5 cycles.
      wait_ready("bp");
      req_valid  = 1'b1;
      op         = 2'b10;
      a          = 64'h123456789ABCDEF0;
      b          = 64'h123456789ABCDEF0;
      resp_ready = 1'b0;
      tick();
      req_valid = 1'b0;
      wait_resp("bp", lat);
      check("bp latency", 64'(lat), 64'(LAT));
      for (int i = 0; i < 5; i++) begin
         check($sformatf("bp hold%0d resp_valid", i), {63'd0, resp_valid}, 64'd1);
         check($sformatf("bp hold%0d result", i), result, 64'd0);
         check($sformatf("bp hold%0d req_ready", i), {63'd0, req_ready}, 64'd0);
`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
         check($sformatf("bp hold%0d zero", i), {63'd0, zero}, 64'd1);
`endif
         tick();
      end
      check("bp still valid", {63'd0, resp_valid}, 64'd1);
      resp_ready = 1'b1;
      tick();
      check("bp release resp_valid", {63'd0, resp_valid}, 64'd0);
      check("bp release req_ready", {63'd0, req_ready}, 64'd1);

      // Operands and op change right after acceptance must not affect the result.
      wait_ready("opchg");
      req_valid = 1'b1;
      op        = 2'b01;
      a         = 64'h1;
      b         = 64'h2;
      tick();
      req_valid = 1'b0;
      a         = '1;
      b         = '1;
      op        = 2'b00;
      wait_resp("opchg", lat);
      check("opchg result", result, 64'h3);
      tick();

      // Reset at the second BUSY cycle aborts the operation.
      wait_ready("rst");
      req_valid = 1'b1;
      op        = 2'b00;
      a         = '1;
      b         = '1;
      tick();
      req_valid = 1'b0;
      tick();
      check("rst partial slice0", {48'd0, result[15:0]}, 64'h000000000000FFFF);
      reset = 1'b1;
      #1;
      check("rst resp_valid", {63'd0, resp_valid}, 64'd0);
      check("rst result", result, 64'd0);
      check("rst req_ready", {63'd0, req_ready}, 64'd1);
      tick();
      reset = 1'b0;
      repeat (5) tick();
      check("rst no response", {63'd0, resp_valid}, 64'd0);
      run_op("post_rst", 2'b10, 64'hF0F0F0F0F0F0F0F0, 64'h0FF00FF00FF00FF0, 64'hFF00FF00FF00FF00);

      // Back-to-back: req_valid stays high through the response handshake.
      wait_ready("b2b");
      req_valid  = 1'b1;
      resp_ready = 1'b1;
      op         = 2'b00;
      a          = 64'hFF00FF00FF00FF00;
      b          = 64'hFFFFFFFF00000000;
      tick();
      op = 2'b01;
      a  = 64'h00000000000000F0;
      b  = 64'h000000000000000F;
      wait_resp("b2b first", lat);
      check("b2b first latency", 64'(lat), 64'(LAT));
      check("b2b first result", result, 64'hFF00FF0000000000);
      tick();
      check("b2b idle req_ready", {63'd0, req_ready}, 64'd1);
      check("b2b idle resp_valid", {63'd0, resp_valid}, 64'd0);
      tick();
      check("b2b second accepted", {63'd0, req_ready}, 64'd0);
      req_valid = 1'b0;
      wait_resp("b2b second", lat);
      check("b2b second latency", 64'(lat), 64'(LAT));
      check("b2b second result", result, 64'h00000000000000FF);
      tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
